// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential BCD-to-binary converter:
//   - state_t          : FSM state encoding (IDLE, LOAD, SHIFT, DONE)
//   - CORR_THRESHOLD   : nibble value at or above which a correction applies
//   - CORR_SUBTRAHEND  : amount removed from a nibble that needs correcting
//   - BCD_MAX_DIGIT    : largest legal decimal digit
//   - nibbleInvalid()  : flags a nibble that is not a decimal digit
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CORR_THRESHOLD  = 4'd8;
  localparam logic [3:0] CORR_SUBTRAHEND = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;

  // A nibble above 9 cannot appear in valid packed BCD.
  function automatic logic nibbleInvalid(input logic [3:0] nibble);
    return nibble > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit_correct.sv
// ---------------------------------------------------------------------------
// bcd_digit_correct
// Per-digit correction for the reverse double-dabble step. After the shift
// right, a BCD nibble that received a bit from the digit above holds a value
// 8 too large in binary terms for a weight that should be 5. Subtracting 3
// restores a correct decimal digit.
// Ports:
//   nibble_i : shifted BCD nibble
//   nibble_o : corrected BCD nibble
// ---------------------------------------------------------------------------
module bcd_digit_correct
  import bcd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [3:0] nibble_o
);

  // Remove the excess from any nibble that crossed the threshold.
  assign nibble_o = (nibble_i >= CORR_THRESHOLD) ? (nibble_i - CORR_SUBTRAHEND) : nibble_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq
// Sequential BCD-to-binary converter using a reverse double-dabble. A shift
// register {bcdPart, binPart} is shifted right once per cycle for WIDTH
// cycles, with every BCD nibble corrected after each shift. At the end the
// binary result sits in binPart.
//
// Parameters:
//   WIDTH  : binary result width in bits
//   DIGITS : number of packed BCD input digits
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-high reset
//   start  : conversion request, only looked at in IDLE
//   bcd    : packed BCD operand, digit 0 in bits [3:0], sampled with start
//   binary : converted result, held until the next done pulse
//   busy   : high whenever the FSM is not in IDLE
//   done   : one-cycle pulse when binary/error are updated
//   error  : invalid-digit or overflow flag, held until the next done pulse
//
// Configuration macro: BCD_TO_BINARY_ERROR_EN
//   defined   : invalid digits skip the shifting and report error; a result
//               that does not fit in WIDTH bits reports error; binary is 0
//               whenever error is set
//   undefined : error is tied low and binary is the low WIDTH bits of the
//               algorithm result
// ---------------------------------------------------------------------------
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIGITS*4-1:0]   bcd,
  output logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH + 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     bcdPart_q, bcdPart_d;
  logic [WIDTH-1:0]  binPart_q, binPart_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  binary_q, binary_d;
  logic              done_q, done_d;

  logic [BW+WIDTH-1:0] shifted;
  logic [BW-1:0]       stepBcd;

  // One algorithm step: shift the whole register right, then correct each
  // BCD digit independently.
  assign shifted = {bcdPart_q, binPart_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    bcd_digit_correct uCorrect (
      .nibble_i (shifted[WIDTH + 4*g +: 4]),
      .nibble_o (stepBcd[4*g +: 4])
    );
  end

`ifdef BCD_TO_BINARY_ERROR_EN
  logic error_q, error_d;
  logic anyInvalid;

  // Scan the freshly loaded operand for non-decimal digits.
  always_comb begin
    anyInvalid = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (nibbleInvalid(bcdPart_q[4*k +: 4])) begin
        anyInvalid = 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Next-state and datapath control. In DONE a nonzero bcdPart means either
  // the value needed more than WIDTH bits or the invalid-digit path skipped
  // the shifting (an invalid digit is itself nonzero), so one test covers
  // both error causes.
  always_comb begin
    state_d   = state_q;
    bcdPart_d = bcdPart_q;
    binPart_d = binPart_q;
    count_d   = count_q;
    binary_d  = binary_q;
    done_d    = 1'b0;
`ifdef BCD_TO_BINARY_ERROR_EN
    error_d   = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bcdPart_d = bcd;
          binPart_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        count_d = '0;
`ifdef BCD_TO_BINARY_ERROR_EN
        state_d = anyInvalid ? DONE : SHIFT;
`else
        state_d = SHIFT;
`endif
      end
      SHIFT: begin
        bcdPart_d = stepBcd;
        binPart_d = shifted[WIDTH-1:0];
        count_d   = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef BCD_TO_BINARY_ERROR_EN
        if (bcdPart_q != '0) begin
          error_d  = 1'b1;
          binary_d = '0;
        end else begin
          error_d  = 1'b0;
          binary_d = binPart_q;
        end
`else
        binary_d = binPart_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bcdPart_q <= '0;
      binPart_q <= '0;
      count_q   <= '0;
      binary_q  <= '0;
      done_q    <= 1'b0;
`ifdef BCD_TO_BINARY_ERROR_EN
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bcdPart_q <= bcdPart_d;
      binPart_q <= binPart_d;
      count_q   <= count_d;
      binary_q  <= binary_d;
      done_q    <= done_d;
`ifdef BCD_TO_BINARY_ERROR_EN
      error_q   <= error_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign binary = binary_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_binary_seq
// Self-checking bench for bcd_to_binary_seq (WIDTH=8, DIGITS=3). Expected
// results come from a decimal reference model: the BCD operand is turned
// into an integer with plain arithmetic and the result rules are applied to
// that integer. Honours BCD_TO_BINARY_ERROR_EN when choosing expectations.
// ---------------------------------------------------------------------------
module tb_bcd_to_binary_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                clock;
  logic                reset;
  logic                start;
  logic [DIGITS*4-1:0] bcd;
  logic [WIDTH-1:0]    binary;
  logic                busy;
  logic                done;
  logic                error;

  int checks;
  int failures;

  bcd_to_binary_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bcd    (bcd),
    .binary (binary),
    .busy   (busy),
    .done   (done),
    .error  (error)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count a comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pack an integer 0..999 into three BCD digits.
  function automatic logic [11:0] toBcd(input int value);
    logic [11:0] r;
    r[11:8] = 4'(value / 100);
    r[7:4]  = 4'((value / 10) % 10);
    r[3:0]  = 4'(value % 10);
    return r;
  endfunction

  // Reference model: decimal value of the digits, then the result rules.
  task automatic modelResult(input logic [11:0] bcdVal, output int expBin,
                             output int expErr, output int expLat,
                             output bit binKnown);
    int value;
    int weight;
    bit invalid;
    value   = 0;
    weight  = 1;
    invalid = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(bcdVal[4*k +: 4]) > 9) invalid = 1'b1;
      value  += int'(bcdVal[4*k +: 4]) * weight;
      weight *= 10;
    end
`ifdef BCD_TO_BINARY_ERROR_EN
    binKnown = 1'b1;
    if (invalid) begin
      expLat = 2;
      expErr = 1;
      expBin = 0;
    end else begin
      expLat = WIDTH + 2;
      if (value >= (1 << WIDTH)) begin
        expErr = 1;
        expBin = 0;
      end else begin
        expErr = 0;
        expBin = value;
      end
    end
`else
    binKnown = !invalid;
    expLat   = WIDTH + 2;
    expErr   = 0;
    expBin   = value % (1 << WIDTH);
`endif
  endtask

  // Issue one conversion from IDLE, wait for done with a bounded budget and
  // check latency, busy, binary and error against the model. Returns just
  // after the edge that raised done.
  task automatic applyStimulus(input logic [11:0] bcdVal);
    int  expBin, expErr, expLat;
    bit  binKnown;
    int  edgeCount;
    int  busyLowSeen;
    bit  gotDone;
    modelResult(bcdVal, expBin, expErr, expLat, binKnown);
    @(negedge clock);
    start = 1'b1;
    bcd   = bcdVal;
    @(posedge clock);
    #1;
    start       = 1'b0;
    busyLowSeen = 0;
    gotDone     = 1'b0;
    edgeCount   = 0;
    for (int n = 1; n <= 20 && !gotDone; n++) begin
      @(posedge clock);
      #1;
      if (done) begin
        gotDone   = 1'b1;
        edgeCount = n;
      end else if (!busy) begin
        busyLowSeen++;
      end
    end
    if (!gotDone) begin
      checkOutput("timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", 32'(edgeCount), 32'(expLat));
      checkOutput("busy_low_before_done", 32'(busyLowSeen), 32'd0);
      checkOutput("error", 32'(error), 32'(expErr));
      if (binKnown) checkOutput("binary", 32'(binary), 32'(expBin));
    end
  endtask

  initial begin
    int doneEdges[$];
    int edgeNo;
    bit doneSeen;
    logic [11:0] rnd;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    bcd      = '0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_binary", 32'(binary), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Largest value that fits: 255, plus done pulse width and hold.
    applyStimulus(12'h255);
    checkOutput("fixed_255", 32'(binary), 32'hFF);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("binary_held", 32'(binary), 32'hFF);

    // Every representable value.
    for (int v = 0; v < 256; v++) begin
      applyStimulus(toBcd(v));
    end

    // First value past the range, and an invalid digit.
    applyStimulus(12'h256);
    applyStimulus(12'h1A3);

    // Random valid operands across the full 000..999 range.
    for (int i = 0; i < 40; i++) begin
      rnd = toBcd(int'($urandom_range(999, 0)));
      applyStimulus(rnd);
    end

    // Random operands with at least one non-decimal digit.
    for (int i = 0; i < 10; i++) begin
      rnd = toBcd(int'($urandom_range(999, 0)));
      rnd[4*$urandom_range(2, 0) +: 4] = 4'($urandom_range(15, 10));
      applyStimulus(rnd);
    end

    // start held high: a conversion every 11 cycles, and changing bcd
    // while busy must not affect the result.
    @(negedge clock);
    start  = 1'b1;
    bcd    = 12'h042;
    edgeNo = 0;
    for (int n = 0; n < 60 && doneEdges.size() < 3; n++) begin
      @(posedge clock);
      #1;
      if (done) begin
        checkOutput("continuous_binary", 32'(binary), 32'h2A);
        checkOutput("continuous_error", 32'(error), 32'd0);
        doneEdges.push_back(n);
        bcd = 12'h042;
        if (doneEdges.size() == 3) start = 1'b0;
      end else if (n == 4 || n == 15 || n == 26) begin
        bcd = 12'h999;
      end
      edgeNo = n;
    end
    if (doneEdges.size() < 3) begin
      checkOutput("continuous_timeout", 32'(doneEdges.size()), 32'd3);
    end else begin
      checkOutput("continuous_first", 32'(doneEdges[0]), 32'(WIDTH + 2));
      checkOutput("continuous_period1", 32'(doneEdges[1] - doneEdges[0]), 32'd11);
      checkOutput("continuous_period2", 32'(doneEdges[2] - doneEdges[1]), 32'd11);
    end
    start = 1'b0;
    @(posedge clock);
    #1;

    // Reset in the middle of SHIFT abandons the conversion.
    @(negedge clock);
    start = 1'b1;
    bcd   = 12'h128;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_binary", 32'(binary), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_error", 32'(error), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    doneSeen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clock);
      #1;
      if (done) doneSeen = 1'b1;
    end
    checkOutput("no_done_after_reset", 32'(doneSeen), 32'd0);
    applyStimulus(12'h128);
    checkOutput("after_reset_binary", 32'(binary), 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
